// File: rtl/denise_sprite_engine.sv
// Sprite serialiser bank: per-channel POS/CTL/DATA/DATB, HSTART compare, 2-bit pixel shifter.
// Define DENISE_SPR_HIRES_EN to add spr_hires/pix_en_hr (second shift per lores pixel).
module denise_sprite_engine #(
    parameter int NUM_SPR = 8,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 3
) (
    input  logic                   C14M,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [1:0]             wr_sel,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   pix_en,
    input  logic [8:0]             hcount,
`ifdef DENISE_SPR_HIRES_EN
    input  logic                   spr_hires,
    input  logic                   pix_en_hr,
`endif
    output logic [2*NUM_SPR-1:0]   spr_pix,
    output logic [NUM_SPR-1:0]     spr_nz,
    output logic [NUM_SPR/2-1:0]   spr_att,
    output logic [NUM_SPR-1:0]     spr_busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic shiftStb;
`ifdef DENISE_SPR_HIRES_EN
    // pix_en and pix_en_hr together still yield a single shift
    assign shiftStb = pix_en | (spr_hires & pix_en_hr);
`else
    assign shiftStb = pix_en;
`endif

    for (genvar n = 0; n < NUM_SPR; n++) begin : g_ch
        logic [15:0]       pos;
        logic [15:0]       ctl;
        logic [DATA_W-1:0] datA;
        logic [DATA_W-1:0] datB;
        logic [DATA_W-1:0] shA;
        logic [DATA_W-1:0] shB;
        logic [CNT_W-1:0]  cnt;
        logic              armed;
        logic              wrHit;
        logic              match;
        logic              busy;
        logic [1:0]        pix;
        logic              unusedCfgBits;

        // out-of-range wr_idx never equals any channel number, so it is dropped here
        assign wrHit = wr_en && (wr_idx == IDX_W'(n));
        assign match = pix_en && armed && (hcount == {pos[7:0], ctl[0]});

        always_ff @(posedge C14M or posedge RESET) begin
            if (RESET) begin
                pos   <= '0;
                ctl   <= '0;
                datA  <= '0;
                datB  <= '0;
                shA   <= '0;
                shB   <= '0;
                cnt   <= '0;
                armed <= 1'b0;
            end else begin
                if (wrHit) begin
                    case (wr_sel)
                        2'd0: pos <= wr_data[15:0];
                        2'd1: begin
                            ctl   <= wr_data[15:0];
                            armed <= 1'b0;
                        end
                        2'd2: begin
                            datA  <= wr_data;
                            armed <= 1'b1;
                        end
                        default: datB <= wr_data;
                    endcase
                end
                if (match) begin
                    shA <= datA;
                    shB <= datB;
                    cnt <= CNT_W'(DATA_W);
                end else if (shiftStb && (cnt != '0)) begin
                    shA <= {shA[DATA_W-2:0], 1'b0};
                    shB <= {shB[DATA_W-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
            end
        end

        assign busy = (cnt != '0);
        assign pix  = busy ? {shB[DATA_W-1], shA[DATA_W-1]} : 2'b00;

        assign spr_pix[2*n +: 2] = pix;
        assign spr_nz[n]         = |pix;
        assign spr_busy[n]       = busy;

        if (n % 2 == 1) begin : g_att
            assign spr_att[n/2] = ctl[7];
        end

        assign unusedCfgBits = ^{pos[15:8], ctl[15:1]};
    end
endmodule
